// File: rtl/mem_resp_ctrl.sv
// Memory response controller: 4-entry direct-mapped tag store that only shapes
// latency (hit = 1 cycle, miss = MISS_LAT+1 cycles) over a write-through backing store.
module mem_resp_ctrl #(
  parameter int MISS_LAT = 4,
  parameter int MEM_AW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [4:0]          r_cnt;
  logic [3:0]          r_vld;
  logic [3:0][10:0]    r_tag;
  logic [15:0]         r_mem [2**MEM_AW];
  logic [15:1]         r_addr;
  logic                r_rd;
  logic                r_hit;
  logic                r_err;

  logic                w_accept;
  logic                w_illegal;
  logic [1:0]          w_idx;
  logic                w_tag_hit;
  logic                w_fill;
  logic [MEM_AW-1:0]   w_widx;
  logic [MEM_AW-1:0]   w_fill_widx;

  assign w_accept    = (r_state != S_WAIT) && (Rd | Wr);
  assign w_illegal   = (Rd & Wr) | Addr[0];
  assign w_idx       = Addr[4:3];
  assign w_tag_hit   = r_vld[w_idx] && (r_tag[w_idx] == Addr[15:5]);
  assign w_widx      = Addr[MEM_AW:1];
  assign w_fill      = (r_state == S_WAIT) && (r_cnt == 5'd1);
  assign w_fill_widx = r_addr[MEM_AW:1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) w_next = (w_illegal || w_tag_hit) ? S_RESP : S_WAIT;
        else          w_next = S_IDLE;
      end
      S_WAIT:  if (r_cnt == 5'd1) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_vld   <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
      DataOut <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= Addr[15:1];
        r_rd   <= Rd;
        r_hit  <= !w_illegal && w_tag_hit;
        r_err  <= w_illegal;
        if (!w_illegal && !w_tag_hit) r_cnt <= 5'(MISS_LAT);
        if (!w_illegal && w_tag_hit && Rd) DataOut <= r_mem[w_widx];
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 5'd1;
        if (w_fill) begin
          r_vld[r_addr[4:3]] <= 1'b1;
          if (r_rd) DataOut <= r_mem[w_fill_widx];
        end
      end
    end
  end

  // Tags and store carry no reset; validity alone decides hits.
  always_ff @(posedge clk) begin
    if (w_fill) r_tag[r_addr[4:3]] <= r_addr[15:5];
    if (w_accept && !w_illegal && Wr) r_mem[w_widx] <= DataIn;
  end

  assign Done     = (r_state == S_RESP);
  assign CacheHit = Done & r_hit;
  assign Err      = Done & r_err;
  assign Stall    = (r_state == S_WAIT);

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed scoreboard bench: issue pushes expected completions, monitor checks each Done.
module tb_mem_resp_ctrl;

  localparam int LAT = 4;

  logic        clk, rst_n;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, Stall, CacheHit, Err;

  mem_resp_ctrl #(.MISS_LAT(LAT), .MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .Err(Err)
  );

  typedef struct {
    int          done_cyc;
    bit          hit;
    bit          err;
    bit          chk;
    logic [15:0] data;
    int          stalls;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  logic [15:0] last_rd = 16'h0;
  bit          rd_known = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: consumes one expectation per Done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) stall_cnt = 0;
    else begin
      if (Stall) stall_cnt++;
      if (Done) begin
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("cachehit", CacheHit, e.hit);
          chk("err", Err, e.err);
          chk("stall_cycles", stall_cnt, e.stalls);
          if (e.chk) chk("dataout", DataOut, e.data);
        end
        stall_cnt = 0;
      end else if (CacheHit || Err) chk("qualifier_without_done", 32'd1, 32'd0);
    end
  end

  // Presents a request at the current negedge and holds it until Done is seen.
  task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                       input bit hit, input bit err, input bit chkd, input logic [15:0] rdata);
    exp_t e;
    int   lat;
    int   n;
    lat = (hit || err) ? 1 : LAT + 1;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    e.done_cyc = cyc + lat;
    e.hit = hit;
    e.err = err;
    e.stalls = lat - 1;
    if (rd && !wr && !err) begin
      e.chk = chkd; e.data = rdata;
      rd_known = chkd; last_rd = rdata;
    end else begin
      e.chk = rd_known; e.data = last_rd;
    end
    q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!Done && n < 40);
    if (!Done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    Rd = 1'b0; Wr = 1'b0; Addr = 16'hFFFF; DataIn = 16'h0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_done", Done, 1'b0);
    chk("rst_stall", Stall, 1'b0);
    chk("rst_hit", CacheHit, 1'b0);
    chk("rst_err", Err, 1'b0);
    chk("rst_dataout", DataOut, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // cold write then read hit
    issue(0, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 16'h0); idle();
    issue(1, 0, 16'h0010, 16'h0,    1, 0, 1, 16'hBEEF); idle();

    // conflict eviction on index 1
    issue(0, 1, 16'h0008, 16'h1111, 0, 0, 0, 16'h0); idle();
    issue(0, 1, 16'h0028, 16'h2222, 0, 0, 0, 16'h0); idle();
    issue(1, 0, 16'h0008, 16'h0,    0, 0, 1, 16'h1111); idle();
    issue(1, 0, 16'h0028, 16'h0,    0, 0, 1, 16'h2222); idle();
    issue(1, 0, 16'h0008, 16'h0,    0, 0, 1, 16'h1111); idle();

    // same-line hit after a miss
    issue(1, 0, 16'h0040, 16'h0,    0, 0, 0, 16'h0); idle();
    issue(0, 1, 16'h0046, 16'h4646, 1, 0, 0, 16'h0); idle();
    issue(1, 0, 16'h0046, 16'h0,    1, 0, 1, 16'h4646); idle();

    // illegal requests leave store and tags alone
    issue(0, 1, 16'h0002, 16'h1234, 0, 0, 0, 16'h0); idle();
    issue(1, 1, 16'h0002, 16'hDEAD, 0, 1, 0, 16'h0); idle();
    issue(1, 0, 16'h0003, 16'h0,    0, 1, 0, 16'h0); idle();

    // back-to-back hits, each presented during the previous RESP
    issue(1, 0, 16'h0002, 16'h0,    1, 0, 1, 16'h1234);
    issue(0, 1, 16'h0004, 16'h5555, 1, 0, 0, 16'h0);
    issue(1, 0, 16'h0004, 16'h0,    1, 0, 1, 16'h5555);
    issue(1, 0, 16'h0010, 16'h0,    1, 0, 1, 16'hBEEF); idle();

    // reset in the second WAIT cycle abandons the miss
    Rd = 1'b1; Addr = 16'h0050;
    @(negedge clk);
    chk("wait1_stall", Stall, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", Stall, 1'b0);
    chk("midrst_done", Done, 1'b0);
    chk("midrst_dataout", DataOut, 16'h0000);
    Rd = 1'b0; Addr = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 16'h0; rd_known = 1'b1;
    repeat (6) @(negedge clk);
    issue(1, 0, 16'h0050, 16'h0, 0, 0, 0, 16'h0); idle();

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
